// File: rtl/event_readout_sequencer.sv
// event_readout_sequencer
//   After each scintillator coincidence, waits out the tube timing window, then
//   steps chip_sel through every tube and reads each 8-bit tube time from
//   chip_data. Each event is packed into a byte frame in an internal
//   first-word-fall-through FIFO and streamed out over a valid/ready byte port.
//
//   Frame: A5, event number, [timestamp hi, lo], tube0..tubeN-1, checksum
//   (checksum = XOR of every byte after the sync byte).
//
//   Optional feature: define TIMESTAMP_EN to add a free-running 16-bit clock
//   counter that is latched on each accepted coincidence and inserted as two
//   bytes after the event number (WINDOW_CYCLES must then be >= 4).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   scin_coinc   coincidence level; its rising edge starts an event
//   chip_sel     tube index driven to the timing stage
//   chip_data    tube time returned for chip_sel
//   out_data     FIFO head byte (0 while empty)
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts out_data this cycle
//   busy         sequencer is not idle
//   event_count  completed frames (wraps)
//   drop_count   rejected coincidences (saturates)
//
// Parameter limits: WINDOW_CYCLES >= 2, SETTLE_CYCLES >= 1, NUM_TUBES >= 2,
// FIFO_DEPTH a power of 2 and at least the frame length.
module event_readout_sequencer #(
  parameter int unsigned NUM_TUBES     = 4,
  parameter int unsigned WINDOW_CYCLES = 255,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scin_coinc,
  output logic [$clog2(NUM_TUBES)-1:0] chip_sel,
  input  logic [7:0]                   chip_data,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [15:0]                  event_count,
  output logic [7:0]                   drop_count
);

  localparam int unsigned SEL_W = $clog2(NUM_TUBES);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
`ifdef TIMESTAMP_EN
  localparam int unsigned FRAME_LEN = NUM_TUBES + 5;
`else
  localparam int unsigned FRAME_LEN = NUM_TUBES + 3;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StWindow,
    StSelect,
    StCapture,
    StChecksum
  } state_e;

  state_e            state_q, state_d;
  logic              coinc_q;
  logic              coinc_edge;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [7:0]        csum_q, csum_d;
  logic [15:0]       event_count_q, event_count_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic              push;
  logic [7:0]        push_data;
  logic              pop;
  logic              space_ok;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [CNT_W-1:0]  free_space;

`ifdef TIMESTAMP_EN
  logic [15:0]       ts_cnt_q;
  logic [15:0]       ts_q, ts_d;
`endif

  // Edge against the registered previous level: a held level counts once.
  assign coinc_edge = scin_coinc & ~coinc_q;

  // Whole frame is reserved at acceptance, so pushes never hit a full FIFO.
  assign free_space = CNT_W'(FIFO_DEPTH) - fifo_cnt_q;
  assign space_ok   = free_space >= CNT_W'(FRAME_LEN);

  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    sel_d         = sel_q;
    csum_d        = csum_q;
    event_count_d = event_count_q;
    drop_count_d  = drop_count_q;
    push          = 1'b0;
    push_data     = 8'h00;
`ifdef TIMESTAMP_EN
    ts_d          = ts_q;
`endif

    if (coinc_edge && !(state_q == StIdle && space_ok) && drop_count_q != 8'hFF) begin
      drop_count_d = drop_count_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (coinc_edge && space_ok) begin
          state_d   = StWindow;
          win_cnt_d = '0;
          csum_d    = 8'h00;
`ifdef TIMESTAMP_EN
          ts_d      = ts_cnt_q;
`endif
        end
      end
      StWindow: begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        if (win_cnt_q == WIN_W'(0)) begin
          push      = 1'b1;
          push_data = 8'hA5;
        end else if (win_cnt_q == WIN_W'(1)) begin
          // Event number is the low byte of the completed-frame counter.
          push      = 1'b1;
          push_data = event_count_q[7:0];
          csum_d    = csum_q ^ event_count_q[7:0];
        end
`ifdef TIMESTAMP_EN
        else if (win_cnt_q == WIN_W'(2)) begin
          push      = 1'b1;
          push_data = ts_q[15:8];
          csum_d    = csum_q ^ ts_q[15:8];
        end else if (win_cnt_q == WIN_W'(3)) begin
          push      = 1'b1;
          push_data = ts_q[7:0];
          csum_d    = csum_q ^ ts_q[7:0];
        end
`endif
        if (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1)) begin
          state_d      = StSelect;
          sel_d        = '0;
          settle_cnt_d = '0;
        end
      end
      StSelect: begin
        settle_cnt_d = settle_cnt_q + SET_W'(1);
        if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        push      = 1'b1;
        push_data = chip_data;
        csum_d    = csum_q ^ chip_data;
        if (sel_q == SEL_W'(NUM_TUBES - 1)) begin
          state_d = StChecksum;
        end else begin
          sel_d        = sel_q + SEL_W'(1);
          settle_cnt_d = '0;
          state_d      = StSelect;
        end
      end
      StChecksum: begin
        push          = 1'b1;
        push_data     = csum_q;
        event_count_d = event_count_q + 16'd1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      coinc_q       <= 1'b0;
      win_cnt_q     <= '0;
      settle_cnt_q  <= '0;
      sel_q         <= '0;
      csum_q        <= 8'h00;
      event_count_q <= 16'h0000;
      drop_count_q  <= 8'h00;
    end else begin
      state_q       <= state_d;
      coinc_q       <= scin_coinc;
      win_cnt_q     <= win_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      sel_q         <= sel_d;
      csum_q        <= csum_d;
      event_count_q <= event_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

`ifdef TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= 16'h0000;
      ts_q     <= 16'h0000;
    end else begin
      ts_cnt_q <= ts_cnt_q + 16'd1;
      ts_q     <= ts_d;
    end
  end
`endif

  // Byte FIFO, first-word-fall-through.
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr_q] : 8'h00;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign chip_sel    = sel_q;
  assign busy        = (state_q != StIdle);
  assign event_count = event_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Self-checking bench for event_readout_sequencer. Stimulus issues coincidences
// and pushes each expected frame into a queue; a monitor pops and compares on
// every out_valid && out_ready handshake. The window is shortened to keep the
// 257-event wrap run fast; all expectations derive from the parameters.
`timescale 1ns/1ps
module tb_event_readout_sequencer;
  localparam int NT    = 4;
  localparam int WIN   = 32;
  localparam int SET   = 2;
  localparam int DEPTH = 32;
`ifdef TIMESTAMP_EN
  localparam int FL = NT + 5;
`else
  localparam int FL = NT + 3;
`endif
  localparam int BUSY_LEN = WIN + NT * (SET + 1) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        scin_coinc = 1'b0;
  logic [1:0]  chip_sel;
  logic [7:0]  chip_data = 8'h00;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [15:0] event_count;
  logic [7:0]  drop_count;

  event_readout_sequencer #(
    .NUM_TUBES    (NT),
    .WINDOW_CYCLES(WIN),
    .SETTLE_CYCLES(SET),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scin_coinc (scin_coinc),
    .chip_sel   (chip_sel),
    .chip_data  (chip_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .event_count(event_count),
    .drop_count (drop_count)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] exp_q[$];
  int         pushed = 0, popped = 0;
  int         busy_start = 0, busy_until = 0;
  int         exp_events = 0, exp_drops = 0;
  logic [7:0] evnum = 8'h00;
  int         rel_cyc = 0;
  logic [7:0] tube_time[NT];
  int         ready_mode = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer ready: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Timing-stage model: data is only valid once chip_sel has been stable
  // for more than SET cycles; before that the bus shows junk.
  logic [1:0] sel_prev = 2'd0;
  int         hold = 0;
  always @(negedge clk) begin
    if (chip_sel != sel_prev) hold = 1;
    else hold = hold + 1;
    sel_prev  = chip_sel;
    chip_data = (hold > SET) ? tube_time[chip_sel] : 8'hEE;
  end

  // Monitor
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("stable_valid", out_valid, 1);
        check("stable_data", out_data, data_prev);
      end
      if (out_valid && out_ready) begin
        popped++;
        check("byte_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("out_byte", out_data, exp_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      check("busy", busy, (cyc >= busy_start && cyc < busy_until));
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Issue a coincidence held high for len cycles; decide accept/drop from the
  // model. out_ready is forced low in the deciding cycle so occupancy is exact.
  task automatic pulse(input int len, input bit rand_t);
    int         c0;
    logic [7:0] cs;
    logic [15:0] ts;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    if (cyc >= busy_until && (DEPTH - (pushed - popped)) >= FL) begin
      c0 = cyc + 1;
      if (rand_t) foreach (tube_time[i]) tube_time[i] = 8'($urandom);
      busy_start = c0;
      busy_until = c0 + BUSY_LEN;
      exp_q.push_back(8'hA5);
      exp_q.push_back(evnum);
      cs = evnum;
      ts = 16'(c0 - 1 - rel_cyc);
`ifdef TIMESTAMP_EN
      exp_q.push_back(ts[15:8]);
      exp_q.push_back(ts[7:0]);
      cs = cs ^ ts[15:8] ^ ts[7:0];
`endif
      for (int i = 0; i < NT; i++) begin
        exp_q.push_back(tube_time[i]);
        cs = cs ^ tube_time[i];
      end
      exp_q.push_back(cs);
      pushed += FL;
      evnum++;
      exp_events++;
    end else if (exp_drops < 255) begin
      exp_drops++;
    end
    scin_coinc = 1'b1;
    repeat (len) @(posedge clk);
    #2 scin_coinc = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < busy_until) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    check("empty_after_drain", out_valid, 0);
  endtask

  task automatic check_counts();
    check("event_count", event_count, exp_events & 16'hFFFF);
    check("drop_count", drop_count, exp_drops);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_chip_sel", chip_sel, 0);
    check("rst_event_count", event_count, 0);
    check("rst_drop_count", drop_count, 0);
    exp_q.delete();
    pushed = 0;
    popped = 0;
    busy_start = 0;
    busy_until = 0;
    exp_events = 0;
    exp_drops = 0;
    evnum = 8'h00;
    @(negedge clk);
    #2 rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  initial begin
    int target;
    foreach (tube_time[i]) tube_time[i] = 8'h00;
    #5;
    do_reset();

    // Single event with fixed tube times
    ready_mode = 1;
    tube_time = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse(1, 1'b0);
    wait_idle();
    drain();
    check_counts();

    // Long level counts once; a second pulse during the window is dropped
    pulse(10, 1'b1);
    repeat (3) @(posedge clk);
    pulse(1, 1'b0);
    wait_idle();
    drain();
    check_counts();

    // Stalled consumer: FIFO fills, later coincidences drop and saturate
    ready_mode = 0;
    repeat (5) begin
      pulse(1, 1'b1);
      wait_idle();
    end
    check_counts();
    repeat (260) pulse(1, 1'b1);
    wait_idle();
    check_counts();
    drain();
    pulse(1, 1'b1);
    wait_idle();
    drain();
    check_counts();

    // Reset while selecting tube 2
    pulse(1, 1'b1);
    target = busy_start + WIN + 2 * (SET + 1);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    #2;
    do_reset();
    pulse(1, 1'b1);
    wait_idle();
    drain();
    check_counts();

    // Event number wrap
    repeat (257) begin
      pulse(1, 1'b1);
      wait_idle();
    end
    drain();
    check_counts();

    // Random traffic with random back-pressure
    ready_mode = 2;
    repeat (80) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      pulse($urandom_range(1, 4), 1'b1);
    end
    wait_idle();
    drain();
    check_counts();

`ifdef TIMESTAMP_EN
    // Coincidence accepted with the timestamp counter at 0x1234
    do_reset();
    target = rel_cyc + 16'h1234 - 1;
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    pulse(1, 1'b1);
    wait_idle();
    drain();
    check_counts();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/event_readout_sequencer.md
Name: event_readout_sequencer

Overview:
- Downstream of the tube-timing stage: after each scintillator coincidence, waits out the timing window, then steps the tube-select lines through every tube and reads each 8-bit tube time off the shared data bus.
- Packs each event into a fixed byte frame in an internal byte FIFO.
- Hands frames to the host/UART side over a valid/ready byte stream.

Parameters:
- NUM_TUBES, 4, tubes read per event; CHIP_SEL width is clog2(NUM_TUBES).
- WINDOW_CYCLES, 255, clocks from accepted coincidence to first tube select; must be at least 2.
- SETTLE_CYCLES, 2, clocks CHIP_SEL is held before CHIP_DATA is sampled (tristate/mux settle).
- FIFO_DEPTH, 32, byte FIFO depth; power of 2, at least the frame length.

Ports:
- CLK  in  1  system clock, 50 MHz (20 ns tick shared with the tube counter).
- RST_N  in  1  reset, asynchronous, active-low.
- SCIN_COINC  in  1  scintillator coincidence, synchronous, one or more cycles high.
- CHIP_SEL  out  2  tube index driven to the timing stage's select input.
- CHIP_DATA  in  8  tube time returned for CHIP_SEL.
- OUT_DATA  out  8  FIFO head byte.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  consumer accepts OUT_DATA this cycle.
- BUSY  out  1  high in any state other than IDLE.
- EVENT_COUNT  out  16  completed frames, wraps at 65535 to 0.
- DROP_COUNT  out  8  rejected coincidences, saturates at 255.

Behaviour:
- Reset (async assert, sync release): state IDLE, CHIP_SEL=0, FIFO empty, OUT_VALID=0, OUT_DATA=0, BUSY=0, EVENT_COUNT=0, DROP_COUNT=0, event number 0. A reset mid-frame discards the partial frame and flushes the FIFO.
- Frame layout, FRAME_LEN = NUM_TUBES+3 bytes:
  - 0xA5 sync byte
  - event number[7:0]
  - tube0..tubeN-1 times
  - checksum = XOR of all bytes after the sync byte
- Coincidence detection: rising edge of SCIN_COINC, registered. A level held high counts once.
- IDLE, on edge:
  - FIFO free space >= FRAME_LEN: accept, go to WINDOW, window counter = 0. Space is reserved, so no push in this frame can overflow.
  - Otherwise: DROP_COUNT++ (saturating), stay IDLE.
- WINDOW: counts to WINDOW_CYCLES-1.
  - Cycle 0 pushes 0xA5; cycle 1 pushes the event number.
  - At terminal count go to SELECT with tube index 0.
- SELECT: drive CHIP_SEL=index for SETTLE_CYCLES clocks, then go to CAPTURE.
- CAPTURE (one clock):
  - Sample CHIP_DATA, push it, XOR it into the checksum.
  - If index==NUM_TUBES-1 go to CHECKSUM; else index++ and return to SELECT.
- CHECKSUM (one clock): push checksum; EVENT_COUNT++; event number++ (8-bit wrap, 0xFF then 0x00); go to IDLE.
- Latency: last frame byte is pushed 1+WINDOW_CYCLES+NUM_TUBES*(SETTLE_CYCLES+1) clocks after the SCIN_COINC edge is sampled.
- A coincidence edge while BUSY: DROP_COUNT++, the event in progress is unaffected.
- FIFO is first-word-fall-through: OUT_DATA is valid in the same cycle OUT_VALID rises. Pop on OUT_VALID&&OUT_READY.
  - Push and pop in the same cycle are both honoured, count unchanged.
  - Pop while empty is ignored.
  - OUT_DATA/OUT_VALID are stable while OUT_VALID&&!OUT_READY.
- CHIP_SEL holds its last value in IDLE; it returns to 0 only on reset.

Optional Feature:
- TIMESTAMP_EN defined:
  - A free-running 16-bit clock counter (reset 0, wraps) is latched on the accepted coincidence.
  - Timestamp[15:8] then [7:0] are inserted after the event number, pushed in WINDOW cycles 2 and 3. WINDOW_CYCLES must be at least 4.
  - FRAME_LEN = NUM_TUBES+5; both bytes are included in the checksum.
- TIMESTAMP_EN undefined: no timestamp counter in the design; frame exactly as above.

Test Plan:
- Single event, defaults, CHIP_DATA returns 0x11,0x22,0x33,0x44 for sel 0..3, OUT_READY=1 -> bytes A5,00,11,22,33,44,44 (checksum 00^11^22^33^44=0x44); EVENT_COUNT=1; BUSY high for 1+255+12 clocks.
- SCIN_COINC held high 10 cycles, then a second pulse during WINDOW -> one frame only, DROP_COUNT=1.
- OUT_READY=0, FIFO_DEPTH=32, 5 events -> 4 frames stored (28 bytes), 5th rejected, DROP_COUNT=1; OUT_DATA stays 0xA5 throughout; after draining, a new event is accepted.
- 257 events -> event byte sequence ...,FE,FF,00; EVENT_COUNT=257.
- RST_N asserted during SELECT of tube 2 -> outputs clear asynchronously, FIFO empty; next event produces a full, correct frame with event number 00.
- TIMESTAMP_EN, coincidence accepted at timestamp 0x1234 -> frame A5,00,12,34,t0..t3,checksum with 9 bytes.
